vector_reg_bank: RTL and testbench

VECTOR_REG_BANK -- requirements
Module: vector_reg_bank

---
 rtl/vreg_pkg.sv | 16 +
 rtl/vreg_addr_map.sv | 35 +++
 rtl/vector_reg_bank.sv | 121 ++++++++++++
 tb/tb_vector_reg_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vreg_pkg.sv
// Shared types and default sizing for the vector register bank.
package vreg_pkg;

   localparam int DEF_LANES     = 4;
   localparam int DEF_LANE_W    = 32;
   localparam int DEF_NREGS     = 16;
   localparam int DEF_VREG_BASE = 16;

   typedef logic [4:0] vaddr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/vreg_addr_map.sv
// Architectural-to-physical address translation for both read ports and the write port.
module vreg_addr_map
   import vreg_pkg::*;
#(
   parameter int NREGS     = DEF_NREGS,
   parameter int VREG_BASE = DEF_VREG_BASE,
   localparam int IDX_W    = $clog2(NREGS)
) (
   input  vaddr_t           rs1,
   input  vaddr_t           rs2,
   input  vaddr_t           rd,
   output logic [IDX_W-1:0] idx1,
   output logic [IDX_W-1:0] idx2,
   output logic [IDX_W-1:0] idxd,
   output logic             ok1,
   output logic             ok2,
   output logic             okd
);

   function automatic logic in_range(input vaddr_t a);
      return (32'(a) >= 32'(VREG_BASE)) && (32'(a) < 32'(VREG_BASE + NREGS));
   endfunction

   function automatic logic [IDX_W-1:0] to_idx(input vaddr_t a);
      return IDX_W'(32'(a) - 32'(VREG_BASE));
   endfunction

   assign ok1  = in_range(rs1);
   assign ok2  = in_range(rs2);
   assign okd  = in_range(rd);
   assign idx1 = to_idx(rs1);
   assign idx2 = to_idx(rs2);
   assign idxd = to_idx(rd);

endmodule

// File: rtl/vector_reg_bank.sv
// Lane-masked vector register bank with a sequential clear engine.
// Define VREG_BYPASS_EN to forward same-cycle write data to the read ports.
module vector_reg_bank
   import vreg_pkg::*;
#(
   parameter int LANES     = DEF_LANES,
   parameter int LANE_W    = DEF_LANE_W,
   parameter int NREGS     = DEF_NREGS,
   parameter int VREG_BASE = DEF_VREG_BASE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [LANES-1:0]        wmask,
   input  vaddr_t                  rs1,
   input  vaddr_t                  rs2,
   input  vaddr_t                  rd,
   input  logic [LANES*LANE_W-1:0] wdata,
   output logic [LANES*LANE_W-1:0] rdata1,
   output logic [LANES*LANE_W-1:0] rdata2,
   input  logic                    clr_req,
   output logic                    clr_busy,
   output logic                    addr_err
);

   localparam int IDX_W = $clog2(NREGS);
   localparam int VW    = LANES * LANE_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

   logic [IDX_W-1:0] idx1, idx2, idxd;
   logic             ok1, ok2, okd;

   vreg_addr_map #(
      .NREGS     (NREGS),
      .VREG_BASE (VREG_BASE)
   ) u_addr_map (
      .rs1  (rs1),
      .rs2  (rs2),
      .rd   (rd),
      .idx1 (idx1),
      .idx2 (idx2),
      .idxd (idxd),
      .ok1  (ok1),
      .ok2  (ok2),
      .okd  (okd)
   );

   state_t           state, state_next;
   logic [IDX_W-1:0] cnt, cnt_next;
   logic [VW-1:0]    regs [NREGS];
   logic             wr_acc;

   assign wr_acc   = rst_n && we && okd && !clr_req && (state == IDLE);
   assign clr_busy = (state == CLEAR);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         CLEAR: begin
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_IDX) state_next = IDLE;
         end
         default: begin
            state_next = CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= CLEAR;
         cnt      <= '0;
         addr_err <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         addr_err <= we && !okd && !clr_req && (state == IDLE);
      end
   end

   // NOTE: the array is deliberately not reset; the CLEAR walk started by reset zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            regs[cnt] <= '0;
         end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
               if (wmask[i]) regs[idxd][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (state == IDLE) begin
         if (ok1) rdata1 = regs[idx1];
         if (ok2) rdata2 = regs[idx2];
`ifdef VREG_BYPASS_EN
         if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
               if (wmask[i] && (rd == rs1)) rdata1[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
               if (wmask[i] && (rd == rs2)) rdata2[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_vector_reg_bank.sv
// Randomised bench for vector_reg_bank against a whole-register behavioural model.
module tb_vector_reg_bank;
   import vreg_pkg::*;

   localparam int LANES  = 4;
   localparam int LANE_W = 32;
   localparam int NREGS  = 16;
   localparam int BASE   = 16;
   localparam int W      = LANES * LANE_W;

   logic           clk = 1'b0;
   logic           rst_n, we, clr_req;
   logic [LANES-1:0] wmask;
   vaddr_t         rs1, rs2, rd;
   logic [W-1:0]   wdata, rdata1, rdata2;
   logic           clr_busy, addr_err;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] mem_m [NREGS];
   int           clear_left;
   logic         exp_err;

   always #5 clk = ~clk;

   vector_reg_bank #(
      .LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS), .VREG_BASE(BASE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wmask(wmask), .rs1(rs1), .rs2(rs2), .rd(rd),
      .wdata(wdata), .rdata1(rdata1), .rdata2(rdata2), .clr_req(clr_req),
      .clr_busy(clr_busy), .addr_err(addr_err)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic bit mapped(input vaddr_t a);
      return (int'(a) >= BASE) && (int'(a) < BASE + NREGS);
   endfunction

   function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                          input logic [LANES-1:0] m);
      logic [W-1:0] r = old;
      for (int i = 0; i < LANES; i++) if (m[i]) r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
      return r;
   endfunction

   function automatic logic [W-1:0] exp_rd(input vaddr_t a);
      logic [W-1:0] v;
      if (clear_left > 0 || !mapped(a)) return '0;
      v = mem_m[int'(a) - BASE];
`ifdef VREG_BYPASS_EN
      if (rst_n && we && !clr_req && mapped(rd) && rd == a) v = merge(v, wdata, wmask);
`endif
      return v;
   endfunction

   task automatic start_clear();
      clear_left = NREGS;
      for (int i = 0; i < NREGS; i++) mem_m[i] = '0;
   endtask

   // One clock: compare outputs at the falling edge, then advance the model on the rising edge.
   task automatic cycle();
      @(negedge clk);
      check("clr_busy", W'(clr_busy), W'(clear_left > 0));
      check("addr_err", W'(addr_err), W'(exp_err));
      check("rdata1", rdata1, exp_rd(rs1));
      check("rdata2", rdata2, exp_rd(rs2));
      @(posedge clk);
      if (!rst_n) begin
         start_clear();
         exp_err = 1'b0;
      end else if (clear_left > 0) begin
         clear_left--;
         exp_err = 1'b0;
      end else if (clr_req) begin
         start_clear();
         exp_err = 1'b0;
      end else if (we) begin
         if (mapped(rd)) mem_m[int'(rd) - BASE] = merge(mem_m[int'(rd) - BASE], wdata, wmask);
         exp_err = !mapped(rd);
      end else begin
         exp_err = 1'b0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; clr_req = 1'b0; wmask = '0; wdata = '0; rd = 5'd16;
   endtask

   function automatic vaddr_t rand_addr();
      return ($urandom_range(0, 3) == 0) ? vaddr_t'($urandom_range(0, 15))
                                         : vaddr_t'($urandom_range(16, 31));
   endfunction

   task automatic count_busy(input string tag, input int expected);
      int n = 0;
      for (int k = 0; k < NREGS + 4; k++) begin
         if (clr_busy === 1'b1) n++;
         cycle();
      end
      check(tag, W'(n), W'(expected));
   endtask

   initial begin
      logic [W-1:0] a_val, b_val, exp_v;
      rst_n = 1'b0; rs1 = 5'd16; rs2 = 5'd31;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      start_clear();
      exp_err = 1'b0;
      cycle();
      rst_n = 1'b1;

      // Power-up clear must last exactly NREGS cycles and leave every register zero.
      count_busy("reset_busy_len", NREGS);
      for (int a = 16; a < 32; a++) begin
         rs1 = vaddr_t'(a); rs2 = vaddr_t'(47 - a);
         cycle();
      end

      // Masked write over a zero register.
      we = 1'b1; rd = 5'd17; wmask = 4'b0101;
      wdata = 128'h44444444_33333333_22222222_11111111;
      cycle();
      idle_inputs(); rs1 = 5'd17;
      #1 check("masked_write", rdata1, 128'h00000000_33333333_00000000_11111111);
      cycle();

      // Same-cycle write and read of register 20.
      a_val = {$urandom, $urandom, $urandom, $urandom};
      b_val = {$urandom, $urandom, $urandom, $urandom};
      we = 1'b1; rd = 5'd20; wmask = 4'b1111; wdata = a_val;
      cycle();
      rs1 = 5'd20; wmask = 4'b0011; wdata = b_val;
`ifdef VREG_BYPASS_EN
      exp_v = {a_val[127:64], b_val[63:0]};
`else
      exp_v = a_val;
`endif
      #1 check("same_cycle_rw", rdata1, exp_v);
      cycle();
      idle_inputs();
      cycle();

      // Unmapped write.
      we = 1'b1; rd = 5'd3; wmask = 4'b1111; wdata = '1; rs1 = 5'd3;
      cycle();
      idle_inputs();
      cycle();
      cycle();

      // Clear request colliding with a write; writes during the clear are ignored.
      clr_req = 1'b1; we = 1'b1; rd = 5'd18; wmask = 4'b1111; wdata = '1; rs1 = 5'd18;
      cycle();
      clr_req = 1'b0;
      for (int k = 0; k < NREGS + 2; k++) begin
         we = 1'b1; rd = vaddr_t'($urandom_range(0, 31)); wmask = 4'($urandom);
         wdata = {$urandom, $urandom, $urandom, $urandom};
         clr_req = 1'($urandom_range(0, 1));
         rs1 = rand_addr(); rs2 = rand_addr();
         if (k >= NREGS - 1) begin we = 1'b0; clr_req = 1'b0; end
         cycle();
      end
      idle_inputs();

      // Reset in the middle of a clear restarts the full sequence.
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      repeat (7) cycle();
      rst_n = 1'b0; we = 1'b1; rd = 5'd21; wmask = '1; wdata = '1;
      cycle();
      rst_n = 1'b1; idle_inputs();
      count_busy("restart_busy_len", NREGS);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         we      = 1'($urandom_range(0, 1));
         wmask   = 4'($urandom);
         rd      = rand_addr();
         wdata   = {$urandom, $urandom, $urandom, $urandom};
         rs1     = ($urandom_range(0, 3) == 0) ? rd : rand_addr();
         rs2     = ($urandom_range(0, 3) == 0) ? rd : rand_addr();
         clr_req = ($urandom_range(0, 59) == 0);
         rst_n   = ($urandom_range(0, 149) != 0);
         cycle();
      end
      rst_n = 1'b1; idle_inputs();
      repeat (NREGS + 2) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
